// File: rtl/avlstrm_stats_pkg.sv
// Shared types and constants for the Avalon-ST statistics monitor.
// The err increment field exists only when STATS_MON_ERR_EN is defined.
package avlstrm_stats_pkg;

  // Width of a lane-count value; covers any practical DATA_W/RULE_W ratio.
  localparam int unsigned LaneCntW = 16;

  // Framing tracker state for one channel.
  typedef enum logic [0:0] {
    StIdle,
    StInPkt
  } ch_state_e;

  // Per-channel counter increments applied in one cycle.
  typedef struct packed {
    logic                flit;
    logic                pkt;
    logic [LaneCntW-1:0] rule;
`ifdef STATS_MON_ERR_EN
    logic                err;
`endif
  } ch_inc_t;

endpackage

// File: rtl/stats_lane_popcnt.sv
// Registered count of non-zero rule-ID lanes in one beat.
// On an EOP beat only lanes lying fully inside the valid bytes are counted.
module stats_lane_popcnt #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned RULE_W  = 16,
  parameter int unsigned EMPTY_W = 6,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned POP_W   = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               vld_i,
  input  logic               eop_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [EMPTY_W-1:0] empty_i,
  input  logic [CH_W-1:0]    ch_i,
  output logic               vld_o,
  output logic [CH_W-1:0]    ch_o,
  output logic [POP_W-1:0]   cnt_o
);

  localparam int unsigned NumLanes     = DATA_W / RULE_W;
  localparam int unsigned BytesPerBeat = DATA_W / 8;
  localparam int unsigned BytesPerLane = RULE_W / 8;

  logic [POP_W-1:0] cnt_d, cnt_q;
  logic             vld_q;
  logic [CH_W-1:0]  ch_q;

  // Count eligible non-zero lanes; lane 0 sits at the MSBs.
  always_comb begin
    int unsigned n_elig;
    n_elig = NumLanes;
    if (eop_i) begin
      n_elig = (BytesPerBeat - 32'(empty_i)) / BytesPerLane;
    end
    cnt_d = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      if ((i < n_elig) && (data_i[DATA_W-1-i*RULE_W -: RULE_W] != '0)) begin
        cnt_d = cnt_d + POP_W'(1);
      end
    end
  end

  // Stage register; a cleared vld_i (e.g. counter clear) drops the slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      ch_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        ch_q  <= ch_i;
        cnt_q <= cnt_d;
      end
    end
  end

  assign vld_o = vld_q;
  assign ch_o  = ch_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/avlstrm_stats_mon.sv
// Passive per-channel flit/packet/rule counters on one Avalon-ST tap,
// with atomic snapshot (optionally clearing) and registered readback.
// Define STATS_MON_ERR_EN to add per-channel framing-error counting.
module avlstrm_stats_mon
  import avlstrm_stats_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned EMPTY_W = $clog2(DATA_W / 8),
  parameter int unsigned RULE_W  = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               in_valid,
  input  logic               in_ready,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic [CH_W-1:0]    in_channel,
  input  logic               cnt_clr,
  input  logic               snap,
  input  logic               snap_clr,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [CNT_W-1:0]   rd_flit,
  output logic [CNT_W-1:0]   rd_pkt,
  output logic [CNT_W-1:0]   rd_rule,
  output logic [CNT_W-1:0]   rd_err,
  output logic               snap_done
);

  localparam int unsigned PopW = $clog2(DATA_W / RULE_W + 1);
  localparam int unsigned IncW = (CNT_W > LaneCntW) ? CNT_W : LaneCntW;
  localparam logic [CNT_W-1:0] CntMax = '1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [IncW-1:0] b);
    logic [IncW:0] s;
    s = (IncW+1)'(a) + (IncW+1)'(b);
    if (s > (IncW+1)'(CntMax)) return CntMax;
    return s[CNT_W-1:0];
  endfunction

  logic beat_ch_ok, rd_ch_ok;
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign beat_ch_ok = 1'b1;
    assign rd_ch_ok   = 1'b1;
  end else begin : g_ch_part
    assign beat_ch_ok = ({1'b0, in_channel} < (CH_W+1)'(NUM_CH));
    assign rd_ch_ok   = ({1'b0, rd_ch} < (CH_W+1)'(NUM_CH));
  end

  logic             beat_cnt, snap_go, live_clr;
  logic             snap_busy_q, snap_done_q;
  logic             pc_vld;
  logic [CH_W-1:0]  pc_ch;
  logic [PopW-1:0]  pc_cnt;
  ch_inc_t          inc       [NUM_CH];
  logic [CNT_W-1:0] flit_q    [NUM_CH];
  logic [CNT_W-1:0] pkt_q     [NUM_CH];
  logic [CNT_W-1:0] rule_q    [NUM_CH];
  logic [CNT_W-1:0] rule_fold [NUM_CH];
  logic [CNT_W-1:0] sh_flit_q [NUM_CH];
  logic [CNT_W-1:0] sh_pkt_q  [NUM_CH];
  logic [CNT_W-1:0] sh_rule_q [NUM_CH];
  logic [CNT_W-1:0] rd_flit_q, rd_pkt_q, rd_rule_q;

  // A clear discards any beat in the same cycle and wins over snap.
  assign beat_cnt = in_valid & in_ready & beat_ch_ok & ~cnt_clr;
  assign snap_go  = snap & ~cnt_clr & ~snap_busy_q;
  assign live_clr = snap_go & snap_clr;

  stats_lane_popcnt #(
    .DATA_W (DATA_W),
    .RULE_W (RULE_W),
    .EMPTY_W(EMPTY_W),
    .CH_W   (CH_W),
    .POP_W  (PopW)
  ) u_popcnt (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .vld_i  (beat_cnt),
    .eop_i  (in_eop),
    .data_i (in_data),
    .empty_i(in_empty),
    .ch_i   (in_channel),
    .vld_o  (pc_vld),
    .ch_o   (pc_ch),
    .cnt_o  (pc_cnt)
  );

`ifdef STATS_MON_ERR_EN
  ch_state_e        st_q     [NUM_CH];
  logic [CNT_W-1:0] err_q    [NUM_CH];
  logic [CNT_W-1:0] sh_err_q [NUM_CH];
  logic [CNT_W-1:0] rd_err_q;

  // Framing tracker: a sop restarts the packet, an eop closes it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int c = 0; c < NUM_CH; c++) st_q[c] <= StIdle;
    end else if (beat_cnt) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_channel == CH_W'(c)) begin
          if (in_sop)      st_q[c] <= in_eop ? StIdle : StInPkt;
          else if (in_eop) st_q[c] <= StIdle;
        end
      end
    end
  end
`endif

  // Per-channel increments: current beat plus the staged popcount.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      inc[c] = '0;
      if (beat_cnt && (in_channel == CH_W'(c))) begin
        inc[c].flit = 1'b1;
        inc[c].pkt  = in_eop;
`ifdef STATS_MON_ERR_EN
        inc[c].err  = (st_q[c] == StIdle) ? ~in_sop : in_sop;
`endif
      end
      if (pc_vld && (pc_ch == CH_W'(c))) inc[c].rule = LaneCntW'(pc_cnt);
      rule_fold[c] = sat_add(rule_q[c], IncW'(inc[c].rule));
    end
  end

  // Live counters; on a clearing snap the staged popcount belongs to the
  // shadow while the snap-cycle beat starts the new live values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        flit_q[c] <= '0;
        pkt_q[c]  <= '0;
        rule_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt_clr) begin
          flit_q[c] <= '0;
          pkt_q[c]  <= '0;
          rule_q[c] <= '0;
        end else begin
          flit_q[c] <= sat_add(live_clr ? '0 : flit_q[c], IncW'(inc[c].flit));
          pkt_q[c]  <= sat_add(live_clr ? '0 : pkt_q[c], IncW'(inc[c].pkt));
          rule_q[c] <= live_clr ? '0 : rule_fold[c];
        end
      end
    end
  end

  // Shadow capture: live state before the snap-cycle beat, popcount folded.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sh_flit_q[c] <= '0;
        sh_pkt_q[c]  <= '0;
        sh_rule_q[c] <= '0;
      end
    end else if (snap_go) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sh_flit_q[c] <= flit_q[c];
        sh_pkt_q[c]  <= pkt_q[c];
        sh_rule_q[c] <= rule_fold[c];
      end
    end
  end

  // Snapshot handshake; done lands together with refreshed readback.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      snap_busy_q <= 1'b0;
      snap_done_q <= 1'b0;
    end else begin
      snap_busy_q <= snap_go;
      snap_done_q <= snap_busy_q;
    end
  end

  // Registered readback mux; out-of-range channels read as zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_flit_q <= '0;
      rd_pkt_q  <= '0;
      rd_rule_q <= '0;
    end else if (rd_ch_ok) begin
      rd_flit_q <= sh_flit_q[rd_ch];
      rd_pkt_q  <= sh_pkt_q[rd_ch];
      rd_rule_q <= sh_rule_q[rd_ch];
    end else begin
      rd_flit_q <= '0;
      rd_pkt_q  <= '0;
      rd_rule_q <= '0;
    end
  end

`ifdef STATS_MON_ERR_EN
  // Error counter, shadow and readback mirror the other counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        err_q[c]    <= '0;
        sh_err_q[c] <= '0;
      end
      rd_err_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt_clr) err_q[c] <= '0;
        else         err_q[c] <= sat_add(live_clr ? '0 : err_q[c], IncW'(inc[c].err));
        if (snap_go) sh_err_q[c] <= err_q[c];
      end
      rd_err_q <= rd_ch_ok ? sh_err_q[rd_ch] : '0;
    end
  end
  assign rd_err = rd_err_q;
`else
  assign rd_err = '0;
`endif

  assign rd_flit   = rd_flit_q;
  assign rd_pkt    = rd_pkt_q;
  assign rd_rule   = rd_rule_q;
  assign snap_done = snap_done_q;

endmodule

// File: tb/tb_avlstrm_stats_mon.sv
// Directed bench for avlstrm_stats_mon: a default instance and a CNT_W=4
// instance share one stimulus stream.
module tb_avlstrm_stats_mon;

`ifdef STATS_MON_ERR_EN
  localparam logic [31:0] ExpErr = 32'd2;
`else
  localparam logic [31:0] ExpErr = 32'd0;
`endif

  logic         Clk;
  logic         Rst_n;
  logic         in_valid, in_ready, in_sop, in_eop;
  logic [511:0] in_data;
  logic [5:0]   in_empty;
  logic [1:0]   in_channel;
  logic         cnt_clr, snap, snap_clr;
  logic [1:0]   rd_ch;
  logic [31:0]  rd_flit, rd_pkt, rd_rule, rd_err;
  logic         snap_done;
  logic [3:0]   s_rd_flit, s_rd_pkt, s_rd_rule, s_rd_err;
  logic         s_snap_done;

  int n_chk;
  int n_pass;

  logic [511:0] d_ones, d_a5, d_alt, d_one;

  avlstrm_stats_mon u_dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .in_empty  (in_empty),
    .in_channel(in_channel),
    .cnt_clr   (cnt_clr),
    .snap      (snap),
    .snap_clr  (snap_clr),
    .rd_ch     (rd_ch),
    .rd_flit   (rd_flit),
    .rd_pkt    (rd_pkt),
    .rd_rule   (rd_rule),
    .rd_err    (rd_err),
    .snap_done (snap_done)
  );

  avlstrm_stats_mon #(.CNT_W(4)) u_sat (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .in_empty  (in_empty),
    .in_channel(in_channel),
    .cnt_clr   (cnt_clr),
    .snap      (snap),
    .snap_clr  (snap_clr),
    .rd_ch     (rd_ch),
    .rd_flit   (s_rd_flit),
    .rd_pkt    (s_rd_pkt),
    .rd_rule   (s_rd_rule),
    .rd_err    (s_rd_err),
    .snap_done (s_snap_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic send(input logic [1:0] ch, input logic sop, input logic eop,
                      input logic [511:0] data, input logic [5:0] empty);
    in_valid = 1'b1; in_channel = ch; in_sop = sop; in_eop = eop;
    in_data = data; in_empty = empty;
    @(negedge Clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Pulses snap (any beat preset by the caller rides along) and waits for done.
  task automatic do_snap(input logic clr);
    logic seen;
    snap = 1'b1; snap_clr = clr;
    @(negedge Clk);
    snap = 1'b0; snap_clr = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (snap_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("snap_done_seen", 64'(seen), 64'd1);
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(negedge Clk);
    cnt_clr = 1'b0;
  endtask

  task automatic read_ch(input logic [1:0] ch);
    rd_ch = ch;
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    d_ones = {32{16'h0001}};
    d_a5   = {32{16'hA5A5}};
    d_alt  = {16{16'h0000, 16'h1234}};
    d_one  = {16'h0001, 496'd0};
    Rst_n = 1'b0;
    in_valid = 1'b0; in_ready = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; in_empty = '0; in_channel = '0;
    cnt_clr = 1'b0; snap = 1'b0; snap_clr = 1'b0; rd_ch = 2'd2;

    // Reset state.
    repeat (3) @(negedge Clk);
    check("rst_rd_flit", 64'(rd_flit), 64'd0);
    check("rst_snap_done", 64'(snap_done), 64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_rd_rule", 64'(rd_rule), 64'd0);

    // Three-beat packet on ch 2, all lanes non-zero; exact snap_done timing.
    send(2'd2, 1'b1, 1'b0, d_ones, 6'd0);
    send(2'd2, 1'b0, 1'b0, d_ones, 6'd0);
    send(2'd2, 1'b0, 1'b1, d_ones, 6'd0);
    snap = 1'b1;
    @(negedge Clk);
    snap = 1'b0;
    check("snap_done_t1", 64'(snap_done), 64'd0);
    @(negedge Clk);
    check("snap_done_t2", 64'(snap_done), 64'd1);
    check("t1_flit", 64'(rd_flit), 64'd3);
    check("t1_pkt", 64'(rd_pkt), 64'd1);
    check("t1_rule", 64'(rd_rule), 64'd96);
    check("t1_err", 64'(rd_err), 64'd0);
    @(negedge Clk);
    check("snap_done_pulse", 64'(snap_done), 64'd0);

    // EOP masking: empty=60 keeps 2 lanes; empty=61 keeps 1; mid beat 16 of 32.
    clear_cnt();
    send(2'd2, 1'b1, 1'b1, d_a5, 6'd60);
    send(2'd1, 1'b1, 1'b0, d_alt, 6'd0);
    send(2'd1, 1'b0, 1'b1, d_a5, 6'd61);
    do_snap(1'b0);
    check("t2_ch2_rule", 64'(rd_rule), 64'd2);
    check("t2_ch2_flit", 64'(rd_flit), 64'd1);
    read_ch(2'd1);
    check("t2_ch1_rule", 64'(rd_rule), 64'd17);
    check("t2_ch1_pkt", 64'(rd_pkt), 64'd1);

    // Valid without ready is not a beat; a beat alongside cnt_clr is dropped.
    clear_cnt();
    rd_ch = 2'd2;
    in_valid = 1'b1; in_ready = 1'b0; in_channel = 2'd2; in_data = d_ones;
    repeat (10) @(negedge Clk);
    in_valid = 1'b0; in_ready = 1'b1;
    cnt_clr = 1'b1; in_valid = 1'b1; in_channel = 2'd3; in_sop = 1'b1; in_eop = 1'b1;
    @(negedge Clk);
    cnt_clr = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    do_snap(1'b0);
    check("t3_flit", 64'(rd_flit), 64'd0);
    check("t3_rule", 64'(rd_rule), 64'd0);
    read_ch(2'd3);
    check("t3_clr_beat", 64'(rd_flit), 64'd0);

    // Clearing snap coincident with a ch 0 beat.
    clear_cnt();
    rd_ch = 2'd0;
    send(2'd0, 1'b1, 1'b1, d_one, 6'd0);
    send(2'd0, 1'b1, 1'b1, d_one, 6'd0);
    in_valid = 1'b1; in_channel = 2'd0; in_sop = 1'b1; in_eop = 1'b1; in_data = d_one;
    do_snap(1'b1);
    check("t4_sh_flit", 64'(rd_flit), 64'd2);
    check("t4_sh_rule", 64'(rd_rule), 64'd2);
    do_snap(1'b0);
    check("t4_live_flit", 64'(rd_flit), 64'd1);
    check("t4_live_pkt", 64'(rd_pkt), 64'd1);
    check("t4_live_rule", 64'(rd_rule), 64'd1);

    // Saturation: 20 single-beat packets.
    clear_cnt();
    for (int i = 0; i < 20; i++) send(2'd0, 1'b1, 1'b1, d_one, 6'd0);
    do_snap(1'b0);
    check("t5_flit_w32", 64'(rd_flit), 64'd20);
    check("t5_rule_w32", 64'(rd_rule), 64'd20);
    check("t5_flit_w4", 64'(s_rd_flit), 64'd15);
    check("t5_pkt_w4", 64'(s_rd_pkt), 64'd15);
    check("t5_rule_w4", 64'(s_rd_rule), 64'd15);

    // Framing errors on ch 1: sop, sop+eop, mid.
    clear_cnt();
    rd_ch = 2'd1;
    send(2'd1, 1'b1, 1'b0, d_one, 6'd0);
    send(2'd1, 1'b1, 1'b1, d_one, 6'd0);
    send(2'd1, 1'b0, 1'b0, d_one, 6'd0);
    do_snap(1'b0);
    check("t6_err", 64'(rd_err), 64'(ExpErr));
    check("t6_err_w4", 64'(s_rd_err), 64'(ExpErr));
    check("t6_pkt", 64'(rd_pkt), 64'd1);
    check("t6_flit", 64'(rd_flit), 64'd3);

    // Reset during a pending snapshot: no done, readback cleared.
    send(2'd1, 1'b1, 1'b0, d_one, 6'd0);
    snap = 1'b1;
    @(negedge Clk);
    snap = 1'b0;
    Rst_n = 1'b0;
    @(negedge Clk);
    check("t7_done_in_rst", 64'(snap_done), 64'd0);
    check("t7_rd_flit", 64'(rd_flit), 64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check("t7_done_after", 64'(snap_done), 64'd0);
    check("t7_rd_pkt", 64'(rd_pkt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
